// File: rtl/boot_pkg.sv
// Shared definitions for the torv32 boot loader: FSM encoding, frame constants
// and memory target codes.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TGT,
        LEN_LO,
        LEN_HI,
        DATA,
        CKSUM,
        RUN,
        ERROR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    // States that belong to a frame in progress (reported on busy, timed out).
    function automatic logic in_frame(input boot_state_e s);
        return (s == TGT) || (s == LEN_LO) || (s == LEN_HI) ||
               (s == DATA) || (s == CKSUM);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler for the boot loader: little-endian byte lanes and the
// running XOR checksum over the frame body.
module boot_word_asm (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        xor_en,
    input  logic        lane_en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word,
    output logic [7:0]  cksum
);

    logic [1:0]  lane;
    logic [23:0] low_bytes;

    // The fourth byte is not stored; it completes the word combinationally.
    assign word_done = lane_en && (lane == 2'd3);
    assign word      = {byte_in, low_bytes};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane      <= 2'd0;
            low_bytes <= 24'd0;
            cksum     <= 8'd0;
        end else if (clear) begin
            lane  <= 2'd0;
            cksum <= 8'd0;
        end else begin
            if (lane_en) begin
                lane      <= lane + 2'd1;
                low_bytes <= {byte_in, low_bytes[23:8]};
            end
            if (xor_en) begin
                cksum <= cksum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/core_boot_loader.sv
// Boot sequencer: keeps the torv32 core in reset while a framed image arrives
// over the UART byte stream, writes it to IMEM/DMEM, checks it, then releases.
module core_boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_BITS      = 14,
    parameter int         DEPTH_WORDS    = 16384,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 boot_skip,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 ld_we,
    output logic                 ld_tgt,
    output logic [ADDR_BITS-1:0] ld_addr,
    output logic [31:0]          ld_data,
    output logic                 core_resetn,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          words_loaded
);

    // Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
    // rx_ready is held high from the first cycle after reset, so the source is
    // never stalled and bytes outside a frame are simply consumed.

    localparam int          TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    boot_state_e state, state_d;

    logic             take;
    logic             frame_start;
    logic             lane_en;
    logic             xor_en;
    logic             word_done;
    logic [31:0]      word;
    logic [7:0]       cksum;
    logic [15:0]      len_q;
    logic [15:0]      len_now;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tgt_load;
    logic             len_lo_load;
    logic             len_hi_load;

    assign take        = rx_valid && rx_ready;
    assign frame_start = take && (state == IDLE) && !boot_skip && (rx_data == SYNC_BYTE);
    assign lane_en     = take && (state == DATA);
    assign xor_en      = take && ((state == TGT) || (state == LEN_LO) ||
                                  (state == LEN_HI) || (state == DATA));
    assign len_now     = {rx_data, len_q[7:0]};

    boot_word_asm u_word_asm (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (frame_start),
        .xor_en    (xor_en),
        .lane_en   (lane_en),
        .byte_in   (rx_data),
        .word_done (word_done),
        .word      (word),
        .cksum     (cksum)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        tgt_load    = 1'b0;
        len_lo_load = 1'b0;
        len_hi_load = 1'b0;
        case (state)
            IDLE: begin
                if (boot_skip) begin
                    state_d = RUN;
                end else if (frame_start) begin
                    state_d = TGT;
                end
            end
            TGT: begin
                if (take) begin
                    tgt_load = 1'b1;
                    state_d  = (rx_data[7:1] != 7'd0) ? ERROR : LEN_LO;
                end
            end
            LEN_LO: begin
                if (take) begin
                    len_lo_load = 1'b1;
                    state_d     = LEN_HI;
                end
            end
            LEN_HI: begin
                if (take) begin
                    len_hi_load = 1'b1;
                    if ({1'b0, len_now} > DEPTH_LIM) begin
                        state_d = ERROR;
                    end else if (len_now == 16'd0) begin
                        state_d = CKSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // words_loaded still holds the index of the word being completed.
                if (word_done && (words_loaded == len_q - 16'd1)) begin
                    state_d = CKSUM;
                end
            end
            CKSUM: begin
                if (take) begin
                    state_d = (rx_data == cksum) ? RUN : ERROR;
                end
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An accepted byte always wins over an expiring timeout.
        if (in_frame(state) && !take && (tmo_cnt == TMO_LAST)) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (take || !in_frame(state)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q <= 16'd0;
        end else if (len_lo_load) begin
            len_q <= {8'd0, rx_data};
        end else if (len_hi_load) begin
            len_q <= len_now;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_ready     <= 1'b0;
            ld_we        <= 1'b0;
            ld_tgt       <= TGT_IMEM;
            ld_addr      <= '0;
            ld_data      <= 32'd0;
            core_resetn  <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            rx_ready    <= 1'b1;
            ld_we       <= word_done;
            core_resetn <= (state == RUN);
            busy        <= in_frame(state_d);
            if (tgt_load) begin
                ld_tgt <= rx_data[0] ? TGT_DMEM : TGT_IMEM;
            end
            if (word_done) begin
                ld_addr <= ADDR_BITS'(words_loaded);
                ld_data <= word;
            end
            if (frame_start) begin
                words_loaded <= 16'd0;
            end else if (word_done) begin
                words_loaded <= words_loaded + 16'd1;
            end
            if (state == ERROR) begin
                err <= 1'b1;
            end else if (frame_start) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_boot_loader.sv
// Directed bench for core_boot_loader: frame-level model predicts writes and
// outcome, a per-cycle compare process checks writes and core reset release.
module tb_core_boot_loader;

    localparam int ADDR_BITS = 14;
    localparam int DEPTH     = 16384;
    localparam int TMO       = 16;
    localparam int W         = 1 + ADDR_BITS + 32;

    logic                 clk;
    logic                 resetn;
    logic                 boot_skip;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 ld_we;
    logic                 ld_tgt;
    logic [ADDR_BITS-1:0] ld_addr;
    logic [31:0]          ld_data;
    logic                 core_resetn;
    logic                 busy;
    logic                 err;
    logic [15:0]          words_loaded;

    int         checks   = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] frame_q[$];
    bit         rel_ok;

    core_boot_loader #(
        .ADDR_BITS      (ADDR_BITS),
        .DEPTH_WORDS    (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .boot_skip    (boot_skip),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .ld_we        (ld_we),
        .ld_tgt       (ld_tgt),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .core_resetn  (core_resetn),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Frame-level model: parse frame_q, queue the writes that must appear and
    // report whether the frame must release the core.
    task automatic model_frame(output bit ok, output logic [7:0] ck);
        int          n;
        int          len;
        logic [7:0]  x;
        logic [31:0] wd;
        n  = frame_q.size();
        ok = 1'b0;
        ck = 8'h00;
        if (n < 2) return;
        if (frame_q[1][7:1] != 7'd0) return;
        if (n < 4) return;
        len = int'(frame_q[2]) + 256 * int'(frame_q[3]);
        if (len > DEPTH) return;
        x = frame_q[1] ^ frame_q[2] ^ frame_q[3];
        for (int w = 0; w < len; w++) begin
            if (4 + 4 * w + 3 >= n) break;
            wd = {frame_q[4 + 4 * w + 3], frame_q[4 + 4 * w + 2],
                  frame_q[4 + 4 * w + 1], frame_q[4 + 4 * w]};
            x  = x ^ wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
            exp_q.push_back({frame_q[1][0], ADDR_BITS'(w), wd});
        end
        ck = x;
        ok = (n == 4 + 4 * len + 1) && (frame_q[n - 1] == x);
    endtask

    // driver: bytes frame_q[lo..hi-1] back to back, caller sits at a negedge
    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            chk("rx_ready", rx_ready, 1);
            rx_data  = frame_q[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(output bit ok, output logic [7:0] ck);
        int n;
        model_frame(ok, ck);
        n = frame_q.size();
        send_range(0, n - 1);
        if (ok) rel_ok = 1'b1;
        send_range(n - 1, n);
    endtask

    task automatic wait_core(input string name);
        int n;
        n = 0;
        while (core_resetn !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(name, core_resetn, 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        rel_ok = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_core_resetn"}, core_resetn, 0);
        chk({p, "_ld_we"}, ld_we, 0);
        chk({p, "_ld_addr"}, ld_addr, 0);
        chk({p, "_ld_data"}, ld_data, 0);
        chk({p, "_ld_tgt"}, ld_tgt, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_words_loaded"}, words_loaded, 0);
        chk({p, "_rx_ready"}, rx_ready, 0);
    endtask

    initial begin
        bit         ok;
        logic [7:0] ck;
        resetn    = 1'b0;
        boot_skip = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rel_ok    = 1'b0;

        // scoreboard: every write and the core reset checked on each cycle
        fork
            begin : compare
                logic [W-1:0] e;
                forever begin
                    @(negedge clk);
                    if (resetn) begin
                        if (ld_we) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_write", {ld_tgt, ld_addr, ld_data}, 0);
                                if ({ld_tgt, ld_addr, ld_data} == 0) chk("unexpected_write_we", ld_we, 0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("write", {ld_tgt, ld_addr, ld_data}, e);
                            end
                        end
                        if (!rel_ok) chk("core_held", core_resetn, 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_values("rst");

        // boot_skip: release within 2 cycles, RUN discards bytes
        boot_skip = 1'b1;
        rel_ok    = 1'b1;
        resetn    = 1'b1;
        repeat (2) @(negedge clk);
        chk("skip_core_resetn", core_resetn, 1);
        chk("skip_err", err, 0);
        chk("skip_busy", busy, 0);
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_range(0, frame_q.size());
        repeat (2) @(negedge clk);
        chk("skip_still_run", core_resetn, 1);
        boot_skip = 1'b0;
        do_reset();

        // garbage then a good IMEM frame; checksum 00^02^00^13^73^10 = 72
        frame_q = '{8'h11, 8'hFF, 8'h5A};
        send_range(0, 3);
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h73, 8'h00, 8'h10, 8'h00, 8'h72};
        model_frame(ok, ck);
        chk("model_ck", ck, 8'h72);
        chk("model_ok", ok, 1);
        chk("model_w0", exp_q[0], {1'b0, 14'd0, 32'h0000_0013});
        chk("model_w1", exp_q[1], {1'b0, 14'd1, 32'h0010_0073});
        exp_q.delete();
        run_frame(ok, ck);
        wait_core("good_core_resetn");
        chk("good_words", words_loaded, 2);
        chk("good_err", err, 0);
        chk("good_busy", busy, 0);
        chk("good_all_writes", exp_q.size(), 0);
        do_reset();

        // bad checksum, then a good frame clears err and releases
        frame_q[12] = 8'h63;
        run_frame(ok, ck);
        chk("bad_model_ok", ok, 0);
        repeat (3) @(negedge clk);
        chk("bad_err", err, 1);
        chk("bad_core", core_resetn, 0);
        chk("bad_words", words_loaded, 2);
        chk("bad_all_writes", exp_q.size(), 0);
        frame_q[12] = 8'h72;
        model_frame(ok, ck);
        send_range(0, 1);
        chk("resync_err_clear", err, 0);
        send_range(1, frame_q.size() - 1);
        rel_ok = 1'b1;
        send_range(frame_q.size() - 1, frame_q.size());
        wait_core("resync_core_resetn");
        chk("resync_err", err, 0);
        chk("resync_words", words_loaded, 2);
        do_reset();

        // oversize length DEPTH+1
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h40};
        model_frame(ok, ck);
        send_range(0, 4);
        repeat (3) @(negedge clk);
        chk("oversize_err", err, 1);
        chk("oversize_busy", busy, 0);
        chk("oversize_no_write", exp_q.size(), 0);

        // illegal target; trailing bytes fall into IDLE and are dropped
        frame_q = '{8'hA5, 8'h02, 8'h01, 8'h00};
        model_frame(ok, ck);
        send_range(0, 1);
        chk("tgt_sync_clears_err", err, 0);
        chk("tgt_busy", busy, 1);
        send_range(1, 4);
        repeat (2) @(negedge clk);
        chk("tgt_err", err, 1);
        chk("tgt_busy_after", busy, 0);

        // timeout after 5 data bytes: one write, ERROR after 16 idle cycles
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73};
        model_frame(ok, ck);
        send_range(0, frame_q.size());
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_busy_before", busy, 1);
        chk("tmo_err_before", err, 0);
        @(negedge clk);
        chk("tmo_busy_after", busy, 0);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_words", words_loaded, 1);
        chk("tmo_one_write", exp_q.size(), 0);

        // asynchronous reset in the middle of DATA
        model_frame(ok, ck);
        send_range(0, frame_q.size());
        resetn = 1'b0;
        #1;
        check_reset_values("midrst");
        chk("midrst_one_write", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // zero-length DMEM frame
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
        run_frame(ok, ck);
        wait_core("zero_core_resetn");
        chk("zero_ld_tgt", ld_tgt, 1);
        chk("zero_words", words_loaded, 0);
        chk("zero_err", err, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
